// File: rtl/goose_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : goose_pkg
//  Purpose  : Shared types and constants for the score keeper: game state
//             encoding, BCD digit geometry and a digit-wise BCD compare.
//  Revision : 1.0  initial release
// ============================================================================
package goose_pkg;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = DIGIT_W * NUM_DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   // True when BCD value a is strictly greater than b. Digits are examined
   // from the most significant down, and the first differing digit decides.
   function automatic logic bcd_gt(input logic [BCD_W-1:0] a,
                                   input logic [BCD_W-1:0] b);
      logic decided;
      logic gt;
      decided = 1'b0;
      gt      = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (!decided) begin
            if (a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W]) begin
               gt      = 1'b1;
               decided = 1'b1;
            end else if (a[i*DIGIT_W +: DIGIT_W] < b[i*DIGIT_W +: DIGIT_W]) begin
               decided = 1'b1;
            end
         end
      end
      return gt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_inc4.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_inc4
//  Purpose  : Combinational +1 on a 4-digit BCD value. At 9999 the result
//             holds at 9999 and the saturated flag is raised.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_inc4
   import goose_pkg::*;
(
   input  logic [BCD_W-1:0] value,
   output logic [BCD_W-1:0] result,
   output logic             saturated
);

   logic [NUM_DIGITS:0] carry;
   logic [BCD_W-1:0]    sum;

   // The +1 enters at the ones digit and ripples through every digit at 9.
   assign carry[0] = 1'b1;

   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
         logic [DIGIT_W-1:0] d;
         assign d          = value[i*DIGIT_W +: DIGIT_W];
         assign carry[i+1] = carry[i] & (d == 4'd9);
         assign sum[i*DIGIT_W +: DIGIT_W] =
            !carry[i]    ? d    :
            (d == 4'd9)  ? 4'd0 :
                           d + 4'd1;
      end
   endgenerate

   // A carry out of the top digit means every digit was 9.
   assign saturated = carry[NUM_DIGITS];
   assign result    = saturated ? value : sum;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Running-game score counter. Scores one point every
//             FRAMES_PER_POINT frames while running, keeps a high score across
//             runs, flags milestone crossings and serves single BCD digits to
//             the display.
//  Revision : 1.0  initial release
// ============================================================================
module score_keeper
   import goose_pkg::*;
#(
   parameter int FRAMES_PER_POINT = 6,
   parameter int MILESTONE        = 100
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_tick,
   input  logic                 game_reset,
   input  logic                 game_halt,
   input  logic                 game_over,
   input  logic [2:0]           digit_sel,
   output logic [DIGIT_W-1:0]   digit_val,
   output logic [BCD_W-1:0]     score_bcd,
   output logic [BCD_W-1:0]     hi_bcd,
   output logic                 new_hi,
   output logic                 milestone_pulse
);

   // Frame count at which the next tick scores a point.
   localparam logic [5:0] LAST_FRAME = 6'(FRAMES_PER_POINT - 1);

   // The score walks up by exactly one from zero, so a counter of increments
   // modulo MILESTONE tracks "score is a multiple of MILESTONE" without any
   // BCD-to-binary conversion. Milestones beyond 9999 can never be reached.
   localparam int              MS_W      = 14;
   localparam bit              MS_ENABLE = (MILESTONE >= 1) && (MILESTONE <= 9999);
   localparam logic [MS_W-1:0] MS_LAST   = MS_ENABLE ? MS_W'(MILESTONE - 1) : '1;

   state_t             state;
   logic [5:0]         frame_cnt;
   logic [MS_W-1:0]    ms_cnt;
   logic [BCD_W-1:0]   inc_result;
   logic               inc_sat;
   logic [BCD_W-1:0]   sel_word;
   logic [DIGIT_W-1:0] sel_digit;

   bcd_inc4 u_inc (
      .value     (score_bcd),
      .result    (inc_result),
      .saturated (inc_sat)
   );

   // Pick the digit addressed by digit_sel from the current score or high score.
   always_comb begin
      sel_word  = digit_sel[2] ? hi_bcd : score_bcd;
      sel_digit = sel_word[3:0];
      case (digit_sel[1:0])
         2'd0:    sel_digit = sel_word[3:0];
         2'd1:    sel_digit = sel_word[7:4];
         2'd2:    sel_digit = sel_word[11:8];
         default: sel_digit = sel_word[15:12];
      endcase
   end

   // Game FSM with score, high score, milestone and digit output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         frame_cnt       <= '0;
         ms_cnt          <= '0;
         score_bcd       <= '0;
         hi_bcd          <= '0;
         new_hi          <= 1'b0;
         milestone_pulse <= 1'b0;
         digit_val       <= '0;
      end else begin
         milestone_pulse <= 1'b0;
         digit_val       <= sel_digit;
         if (game_reset) begin
            // Restart wins over everything else; the high score survives.
            state     <= IDLE;
            frame_cnt <= '0;
            ms_cnt    <= '0;
            score_bcd <= '0;
            new_hi    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (!game_halt && !game_over) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (game_over) begin
                     // End of run beats a coincident tick: compare pre-tick score.
                     state <= OVER;
                     if (bcd_gt(score_bcd, hi_bcd)) begin
                        hi_bcd <= score_bcd;
                        new_hi <= 1'b1;
                     end
                  end else if (!game_halt && frame_tick) begin
                     if (frame_cnt == LAST_FRAME) begin
                        frame_cnt <= '0;
                        if (!inc_sat) begin
                           score_bcd <= inc_result;
                           if (ms_cnt == MS_LAST) begin
                              ms_cnt          <= '0;
                              milestone_pulse <= MS_ENABLE;
                           end else begin
                              ms_cnt <= ms_cnt + 1'b1;
                           end
                        end
                     end else begin
                        frame_cnt <= frame_cnt + 6'd1;
                     end
                  end
               end
               OVER: begin
                  state <= OVER;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Self-checking bench for score_keeper: directed scenarios plus a
//             randomized run against an integer-arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_score_keeper;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_tick;
   logic        game_reset;
   logic        game_halt;
   logic        game_over;
   logic [2:0]  digit_sel;
   logic [3:0]  digit_val;
   logic [15:0] score_bcd;
   logic [15:0] hi_bcd;
   logic        new_hi;
   logic        milestone_pulse;

   int n_cmp = 0;
   int n_bad = 0;
   int pulse_cnt = 0;

   score_keeper #(
      .FRAMES_PER_POINT (6),
      .MILESTONE        (100)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_tick      (frame_tick),
      .game_reset      (game_reset),
      .game_halt       (game_halt),
      .game_over       (game_over),
      .digit_sel       (digit_sel),
      .digit_val       (digit_val),
      .score_bcd       (score_bcd),
      .hi_bcd          (hi_bcd),
      .new_hi          (new_hi),
      .milestone_pulse (milestone_pulse)
   );

   always #5 clk = ~clk;

   // Decimal integer to four packed BCD digits.
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // One clock, then sample just after the edge; tallies milestone pulses.
   task automatic step();
      @(posedge clk);
      #1;
      if (milestone_pulse === 1'b1) pulse_cnt++;
   endtask

   task automatic tick_n(input int n);
      frame_tick = 1'b1;
      repeat (n) step();
      frame_tick = 1'b0;
   endtask

   // Restart pulse followed by the cycle that moves IDLE to RUN.
   task automatic start_run();
      game_reset = 1'b1;
      step();
      game_reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_tick = 1'b0; game_reset = 1'b0;
      game_halt = 1'b0; game_over = 1'b0; digit_sel = 3'd0;
      step(); step();
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_hi: got %h want 0000", hi_bcd); end
      n_cmp++; if (new_hi !== 1'b0) begin n_bad++; $display("FAIL reset_new_hi: got %b want 0", new_hi); end
      n_cmp++; if (milestone_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", milestone_pulse); end
      n_cmp++; if (digit_val !== 4'd0) begin n_bad++; $display("FAIL reset_digit: got %h want 0", digit_val); end
      rst_n = 1'b1;
   endtask

   task automatic test_count();
      step();                      // IDLE -> RUN
      tick_n(12);
      n_cmp++; if (score_bcd !== 16'h0002) begin n_bad++; $display("FAIL count_score: got %h want 0002", score_bcd); end
      digit_sel = 3'd0; step();
      n_cmp++; if (digit_val !== 4'd2) begin n_bad++; $display("FAIL count_digit0: got %h want 2", digit_val); end
      digit_sel = 3'd1; step();
      n_cmp++; if (digit_val !== 4'd0) begin n_bad++; $display("FAIL count_digit1: got %h want 0", digit_val); end
   endtask

   task automatic test_milestone();
      start_run();
      pulse_cnt = 0;
      tick_n(594);
      n_cmp++; if (score_bcd !== 16'h0099) begin n_bad++; $display("FAIL ms_preload: got %h want 0099", score_bcd); end
      n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL ms_early_pulse: got %0d want 0", pulse_cnt); end
      tick_n(6);
      n_cmp++; if (score_bcd !== 16'h0100) begin n_bad++; $display("FAIL ms_score100: got %h want 0100", score_bcd); end
      n_cmp++; if (milestone_pulse !== 1'b1) begin n_bad++; $display("FAIL ms_pulse_now: got %b want 1", milestone_pulse); end
      step();
      n_cmp++; if (milestone_pulse !== 1'b0) begin n_bad++; $display("FAIL ms_pulse_width: got %b want 0", milestone_pulse); end
      n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL ms_pulse_count: got %0d want 1", pulse_cnt); end
      tick_n(54);
      pulse_cnt = 0;
      tick_n(6);
      n_cmp++; if (score_bcd !== 16'h0110) begin n_bad++; $display("FAIL ms_score110: got %h want 0110", score_bcd); end
      n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL ms_no_pulse110: got %0d want 0", pulse_cnt); end
   endtask

   task automatic test_over_coincident();
      start_run();
      tick_n(252);
      tick_n(5);
      frame_tick = 1'b1; game_over = 1'b1;
      step();
      frame_tick = 1'b0;
      n_cmp++; if (score_bcd !== 16'h0042) begin n_bad++; $display("FAIL over_score: got %h want 0042", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0042) begin n_bad++; $display("FAIL over_hi: got %h want 0042", hi_bcd); end
      n_cmp++; if (new_hi !== 1'b1) begin n_bad++; $display("FAIL over_new_hi: got %b want 1", new_hi); end
      game_over = 1'b0;
      tick_n(12);
      n_cmp++; if (score_bcd !== 16'h0042) begin n_bad++; $display("FAIL over_hold: got %h want 0042", score_bcd); end
   endtask

   task automatic test_hi_retained();
      start_run();
      n_cmp++; if (hi_bcd !== 16'h0042) begin n_bad++; $display("FAIL hi_after_restart: got %h want 0042", hi_bcd); end
      n_cmp++; if (new_hi !== 1'b0) begin n_bad++; $display("FAIL new_hi_cleared: got %b want 0", new_hi); end
      tick_n(180);
      game_over = 1'b1; step(); game_over = 1'b0;
      n_cmp++; if (score_bcd !== 16'h0030) begin n_bad++; $display("FAIL hi_run_score: got %h want 0030", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0042) begin n_bad++; $display("FAIL hi_kept: got %h want 0042", hi_bcd); end
      n_cmp++; if (new_hi !== 1'b0) begin n_bad++; $display("FAIL hi_no_new: got %b want 0", new_hi); end
      digit_sel = 3'd5; step();
      n_cmp++; if (digit_val !== 4'd4) begin n_bad++; $display("FAIL hi_digit5: got %h want 4", digit_val); end
      game_reset = 1'b1; step(); game_reset = 1'b0;
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL hi_reset_score: got %h want 0000", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0042) begin n_bad++; $display("FAIL hi_reset_hi: got %h want 0042", hi_bcd); end
   endtask

   task automatic test_reset_midrun();
      start_run();
      tick_n(30);
      digit_sel = 3'd4;
      n_cmp++; if (score_bcd !== 16'h0005) begin n_bad++; $display("FAIL mid_score: got %h want 0005", score_bcd); end
      rst_n = 1'b0; step(); rst_n = 1'b1;
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_score: got %h want 0000", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_hi: got %h want 0000", hi_bcd); end
      n_cmp++; if (new_hi !== 1'b0) begin n_bad++; $display("FAIL mid_rst_new_hi: got %b want 0", new_hi); end
      n_cmp++; if (digit_val !== 4'd0) begin n_bad++; $display("FAIL mid_rst_digit: got %h want 0", digit_val); end
      step();
      n_cmp++; if (digit_val !== 4'd0) begin n_bad++; $display("FAIL mid_post_digit: got %h want 0", digit_val); end
   endtask

   task automatic test_saturate_halt();
      start_run();
      tick_n(63);
      game_halt = 1'b1; tick_n(30); game_halt = 1'b0;
      n_cmp++; if (score_bcd !== 16'h0010) begin n_bad++; $display("FAIL halt_score: got %h want 0010", score_bcd); end
      tick_n(3);
      n_cmp++; if (score_bcd !== 16'h0011) begin n_bad++; $display("FAIL halt_resume: got %h want 0011", score_bcd); end
      pulse_cnt = 0;
      tick_n(59994 - 66);
      n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_reach: got %h want 9999", score_bcd); end
      n_cmp++; if (pulse_cnt !== 99) begin n_bad++; $display("FAIL sat_milestones: got %0d want 99", pulse_cnt); end
      pulse_cnt = 0;
      tick_n(12);
      n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_hold: got %h want 9999", score_bcd); end
      n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL sat_no_pulse: got %0d want 0", pulse_cnt); end
      game_over = 1'b1; step(); game_over = 1'b0;
      n_cmp++; if (hi_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_hi: got %h want 9999", hi_bcd); end
   endtask

   // Random traffic against a model kept as plain integers and a run phase.
   task automatic test_random();
      int m_score, m_hi, m_frames, m_phase;
      bit m_new, m_pulse;
      int src, exp_digit;
      rst_n = 1'b0; frame_tick = 1'b0; game_reset = 1'b0;
      game_halt = 1'b0; game_over = 1'b0;
      step(); rst_n = 1'b1;
      m_score = 0; m_hi = 0; m_frames = 0; m_phase = 0; m_new = 1'b0; m_pulse = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         frame_tick = ($urandom_range(0, 1) == 1);
         game_halt  = ($urandom_range(0, 7) == 0);
         if (game_over) game_over = ($urandom_range(0, 3) != 0);
         else           game_over = ($urandom_range(0, 199) == 0);
         game_reset = ($urandom_range(0, 299) == 0);
         digit_sel  = 3'($urandom_range(0, 7));
         src = (digit_sel < 4) ? m_score : m_hi;
         for (int k = 0; k < int'(digit_sel[1:0]); k++) src = src / 10;
         exp_digit = src % 10;
         step();
         m_pulse = 1'b0;
         if (game_reset) begin
            m_score = 0; m_frames = 0; m_new = 1'b0; m_phase = 0;
         end else if (m_phase == 0) begin
            if (!game_halt && !game_over) m_phase = 1;
         end else if (m_phase == 1) begin
            if (game_over) begin
               m_phase = 2;
               if (m_score > m_hi) begin m_hi = m_score; m_new = 1'b1; end
            end else if (!game_halt && frame_tick) begin
               m_frames++;
               if (m_frames == 6) begin
                  m_frames = 0;
                  if (m_score < 9999) begin
                     m_score++;
                     m_pulse = (m_score % 100 == 0);
                  end
               end
            end
         end
         n_cmp++; if (score_bcd !== to_bcd(m_score)) begin n_bad++; $display("FAIL rnd_score c=%0d: got %h want %h", c, score_bcd, to_bcd(m_score)); end
         n_cmp++; if (hi_bcd !== to_bcd(m_hi)) begin n_bad++; $display("FAIL rnd_hi c=%0d: got %h want %h", c, hi_bcd, to_bcd(m_hi)); end
         n_cmp++; if (new_hi !== m_new) begin n_bad++; $display("FAIL rnd_new_hi c=%0d: got %b want %b", c, new_hi, m_new); end
         n_cmp++; if (milestone_pulse !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse c=%0d: got %b want %b", c, milestone_pulse, m_pulse); end
         n_cmp++; if (digit_val !== 4'(exp_digit)) begin n_bad++; $display("FAIL rnd_digit c=%0d: got %h want %h", c, digit_val, 4'(exp_digit)); end
      end
      game_over = 1'b0; game_reset = 1'b0; frame_tick = 1'b0; game_halt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_milestone();
      test_over_coincident();
      test_hi_retained();
      test_reset_midrun();
      test_saturate_halt();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
